// File: rtl/fetch_npc_if.sv
// Fetch/next-PC bundle shared between the fetch stage and the rest of the core.
// The slave side is the fetch_npc block itself; the master side is whoever
// supplies the hazard, branch-compare and instruction-memory inputs.
interface fetch_npc_if;
    logic        stall;
    logic [31:0] instr_f;
    logic        cmpout;
    logic [31:0] rs_data_d;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        redirect_d;

    modport master (
        output stall,
        output instr_f,
        output cmpout,
        output rs_data_d,
        input  pc_f,
        input  instr_d,
        input  pc_d,
        input  pc8_d,
        input  redirect_d
    );

    modport slave (
        input  stall,
        input  instr_f,
        input  cmpout,
        input  rs_data_d,
        output pc_f,
        output instr_d,
        output pc_d,
        output pc8_d,
        output redirect_d
    );
endinterface

// File: rtl/fetch_npc.sv
// Fetch-stage PC register, next-PC selection and IF/ID pipeline register.
// Control transfers resolve while the instruction sits in D and have one
// architectural delay slot: by the time D redirects, pc_f already points at
// the delay-slot instruction, so only the following fetch goes to the target.
module fetch_npc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    fetch_npc_if.slave  bus
);

    // Kind of control transfer carried by the instruction in D.
    typedef enum logic [1:0] {
        XFER_NONE,
        XFER_BRANCH,
        XFER_JUMP,
        XFER_REGJUMP
    } xfer_e;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    logic [31:0] pc_f_q;
    logic [31:0] instr_d_q;
    logic [31:0] pc_d_q;
    logic [31:0] pc8_d_q;

    xfer_e       xfer;
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [5:0]  funct;
    logic [15:0] imm;

    logic [31:0] pc_d_plus4;
    logic [31:0] branch_off;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] seq_pc;
    logic        branch_taken;
    logic [31:0] next_pc;
    logic        redirect;

    assign op    = instr_d_q[31:26];
    assign rt    = instr_d_q[20:16];
    assign funct = instr_d_q[5:0];
    assign imm   = instr_d_q[15:0];

    // Classify the instruction in D; anything not listed (movz etc.) is not a transfer.
    always_comb begin
        xfer = XFER_NONE;
        case (op)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                xfer = XFER_BRANCH;
            end
            OP_REGIMM: begin
                if (rt == RT_BLTZ || rt == RT_BGEZ || rt == RT_BGEZAL) begin
                    xfer = XFER_BRANCH;
                end
            end
            OP_J, OP_JAL: begin
                xfer = XFER_JUMP;
            end
            OP_SPECIAL: begin
                if (funct == FN_JR || funct == FN_JALR) begin
                    xfer = XFER_REGJUMP;
                end
            end
            default: begin
                xfer = XFER_NONE;
            end
        endcase
    end

    // Candidate targets; all adds wrap silently at 32 bits.
    always_comb begin
        pc_d_plus4    = pc_d_q + 32'd4;
        branch_off    = {{14{imm[15]}}, imm, 2'b00};
        branch_target = pc_d_plus4 + branch_off;
        jump_target   = {pc_d_plus4[31:28], instr_d_q[25:0], 2'b00};
        seq_pc        = pc_f_q + 32'd4;
    end

    // Next-PC priority: register jump, jump, taken branch, then sequential.
    always_comb begin
        next_pc      = seq_pc;
        branch_taken = (xfer == XFER_BRANCH) && bus.cmpout;
        redirect     = 1'b0;
        if (xfer == XFER_REGJUMP) begin
            next_pc  = bus.rs_data_d;
            redirect = 1'b1;
        end else if (xfer == XFER_JUMP) begin
            next_pc  = jump_target;
            redirect = 1'b1;
        end else if (branch_taken) begin
            next_pc  = branch_target;
            redirect = 1'b1;
        end
    end

    // PC and IF/ID registers; a stall freezes everything so a branch in D is re-evaluated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f_q    <= RESET_PC;
            instr_d_q <= 32'd0;
            pc_d_q    <= RESET_PC;
            pc8_d_q   <= RESET_PC + 32'd8;
        end else if (!bus.stall) begin
            pc_f_q    <= next_pc;
            instr_d_q <= bus.instr_f;
            pc_d_q    <= pc_f_q;
            pc8_d_q   <= pc_f_q + 32'd8;
        end
    end

    assign bus.pc_f       = pc_f_q;
    assign bus.instr_d    = instr_d_q;
    assign bus.pc_d       = pc_d_q;
    assign bus.pc8_d      = pc8_d_q;
    assign bus.redirect_d = redirect;

endmodule

// File: tb/tb_fetch_npc.sv
// Bench for fetch_npc: the driver pushes the expected outputs of every cycle
// into a queue from an instruction-level model; an independent monitor pops
// and compares once per cycle.
module tb_fetch_npc;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef struct {
        logic [31:0] pc_f;
        logic [31:0] instr_d;
        logic [31:0] pc_d;
        logic [31:0] pc8_d;
        logic        redirect;
    } exp_t;

    logic clk;
    logic reset;

    fetch_npc_if bus ();

    fetch_npc #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sb[$];
    int   checks;
    int   errors;

    logic [31:0] m_pc_f;
    logic [31:0] m_instr_d;
    logic [31:0] m_pc_d;

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    // 0 = no transfer, 1 = conditional branch, 2 = absolute jump, 3 = register jump
    function automatic int model_kind(input logic [31:0] ins);
        int op;
        int rt;
        int fn;
        op = int'(ins[31:26]);
        rt = int'(ins[20:16]);
        fn = int'(ins[5:0]);
        if (op >= 4 && op <= 7) return 1;
        if (op == 1 && (rt == 0 || rt == 1 || rt == 17)) return 1;
        if (op == 2 || op == 3) return 2;
        if (op == 0 && (fn == 8 || fn == 9)) return 3;
        return 0;
    endfunction

    function automatic logic model_redirect(input logic [31:0] ins, input logic cmp);
        int k;
        k = model_kind(ins);
        return (k == 2) || (k == 3) || (k == 1 && cmp);
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] pcf, input logic [31:0] ins,
                                               input logic [31:0] pcd, input logic cmp,
                                               input logic [31:0] rs);
        int          k;
        logic [31:0] seq_d;
        logic [31:0] offs;
        k     = model_kind(ins);
        seq_d = pcd + 32'd4;
        offs  = 32'($signed(ins[15:0])) * 32'd4;
        if (k == 3) return rs;
        if (k == 2) return (seq_d & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
        if (k == 1 && cmp) return seq_d + offs;
        return pcf + 32'd4;
    endfunction

    task automatic model_reset();
        m_pc_f    = RESET_PC;
        m_instr_d = 32'd0;
        m_pc_d    = RESET_PC;
    endtask

    task automatic compare32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compare32("pc_f", bus.pc_f, e.pc_f);
        compare32("instr_d", bus.instr_d, e.instr_d);
        compare32("pc_d", bus.pc_d, e.pc_d);
        compare32("pc8_d", bus.pc8_d, e.pc8_d);
        compare32("redirect_d", 32'(bus.redirect_d), 32'(e.redirect));
    endtask

    // One cycle of stimulus: drive at negedge, record expectation, advance model.
    task automatic applyStimulus(input logic rst, input logic st, input logic [31:0] ins,
                                 input logic cmp, input logic [31:0] rs);
        exp_t        e;
        logic [31:0] nxt;
        @(negedge clk);
        reset         = rst;
        bus.stall     = st;
        bus.instr_f   = ins;
        bus.cmpout    = cmp;
        bus.rs_data_d = rs;
        if (rst) model_reset();
        e.pc_f     = m_pc_f;
        e.instr_d  = m_instr_d;
        e.pc_d     = m_pc_d;
        e.pc8_d    = m_pc_d + 32'd8;
        e.redirect = model_redirect(m_instr_d, cmp);
        sb.push_back(e);
        if (!rst && !st) begin
            nxt       = model_next(m_pc_f, m_instr_d, m_pc_d, cmp, rs);
            m_pc_d    = m_pc_f;
            m_instr_d = ins;
            m_pc_f    = nxt;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [4:0]  rt;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return r;
            1: return {6'(4 + $urandom_range(0, 3)), r[25:0]};
            2: begin
                case ($urandom_range(0, 3))
                    0: rt = 5'd0;
                    1: rt = 5'd1;
                    2: rt = 5'd17;
                    default: rt = 5'($urandom);
                endcase
                return {6'b000001, r[25:21], rt, r[15:0]};
            end
            3: return {6'(2 + $urandom_range(0, 1)), r[25:0]};
            4: return {6'b000000, r[25:6], 6'(8 + $urandom_range(0, 1))};
            5: return {6'b000000, r[25:6], 6'b001010};
            6: return 32'd0;
            default: return {6'b000000, r[25:0]};
        endcase
    endfunction

    // Monitor: compare once per cycle, well away from the posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        logic rst_r;
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.stall     = 1'b0;
        bus.instr_f   = 32'd0;
        bus.cmpout    = 1'b0;
        bus.rs_data_d = 32'd0;
        model_reset();

        // Reset then sequential nop fetch.
        applyStimulus(1, 0, 32'd0, 0, 32'd0);
        applyStimulus(0, 0, 32'd0, 0, 32'd0);
        applyStimulus(0, 0, 32'd0, 0, 32'd0);
        applyStimulus(0, 0, 32'd0, 0, 32'd0);
        // Reset pulsed between edges while running.
        applyStimulus(1, 0, 32'd0, 0, 32'd0);

        // Taken beq at 0x3004 with imm 3, delay slot at 0x3008.
        applyStimulus(0, 0, 32'd0, 0, 32'd0);
        applyStimulus(0, 0, 32'h1000_0003, 0, 32'd0);
        applyStimulus(0, 0, 32'h2401_0001, 1, 32'd0);
        applyStimulus(0, 0, 32'd0, 0, 32'd0);
        applyStimulus(0, 0, 32'd0, 0, 32'd0);

        // Same beq not taken.
        applyStimulus(1, 0, 32'd0, 0, 32'd0);
        applyStimulus(0, 0, 32'd0, 0, 32'd0);
        applyStimulus(0, 0, 32'h1000_0003, 0, 32'd0);
        applyStimulus(0, 0, 32'h2401_0001, 0, 32'd0);
        applyStimulus(0, 0, 32'd0, 0, 32'd0);

        // Backward bgez at 0x3010 with imm -1.
        applyStimulus(1, 0, 32'd0, 0, 32'd0);
        repeat (4) applyStimulus(0, 0, 32'd0, 0, 32'd0);
        applyStimulus(0, 0, 32'h0401_FFFF, 0, 32'd0);
        applyStimulus(0, 0, 32'd0, 1, 32'd0);
        applyStimulus(0, 0, 32'd0, 0, 32'd0);

        // jal at 0x3000 to index 0xC10, then jr to 0x3100 with cmpout=1.
        applyStimulus(1, 0, 32'd0, 0, 32'd0);
        applyStimulus(0, 0, 32'h0C00_0C10, 0, 32'd0);
        applyStimulus(0, 0, 32'h03E0_0008, 0, 32'd0);
        applyStimulus(0, 0, 32'd0, 1, 32'h0000_3100);
        applyStimulus(0, 0, 32'd0, 0, 32'd0);

        // bne in D stalled two cycles while cmpout rises, then released.
        applyStimulus(1, 0, 32'd0, 0, 32'd0);
        applyStimulus(0, 0, 32'h1422_0004, 0, 32'd0);
        applyStimulus(0, 1, 32'h2401_0002, 0, 32'd0);
        applyStimulus(0, 1, 32'h2401_0002, 1, 32'd0);
        applyStimulus(0, 0, 32'h2401_0002, 1, 32'd0);
        applyStimulus(0, 0, 32'd0, 0, 32'd0);

        // movz in D with cmpout=1 must not redirect.
        applyStimulus(0, 0, 32'h0022_180A, 0, 32'd0);
        applyStimulus(0, 0, 32'd0, 1, 32'd0);
        applyStimulus(0, 0, 32'd0, 0, 32'd0);

        // Reset during a stalled, taken branch.
        applyStimulus(0, 0, 32'h1000_0010, 0, 32'd0);
        applyStimulus(0, 1, 32'd0, 1, 32'd0);
        applyStimulus(1, 1, 32'd0, 1, 32'd0);
        applyStimulus(0, 0, 32'd0, 1, 32'd0);
        applyStimulus(0, 0, 32'd0, 0, 32'd0);

        // Randomized traffic with occasional stalls and resets.
        for (int i = 0; i < 400; i++) begin
            rst_r = ($urandom_range(0, 59) == 0);
            applyStimulus(rst_r, ($urandom_range(0, 3) == 0), rand_instr(),
                          1'($urandom), ($urandom_range(0, 1) == 0) ? $urandom
                                                                     : 32'h0000_3000 + 32'($urandom_range(0, 255)));
        end

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_npc.md
# fetch_npc

Fetch-stage PC register, next-PC selector and IF/ID pipeline register of the five-stage MIPS core. Decodes the control-transfer instruction held in D, takes the D-stage branch comparator result (`cmpout`) and the forwarded rs value, and redirects fetch. Branches and jumps resolve in D with one architectural delay slot; there is no flush path.

## Interface
- `RESET_PC`, 32'h0000_3000: PC after reset.
- `clk` in 1: the single clock; all state updates on its posedge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `stall` in 1: from the hazard unit; freezes PC and IF/ID.
- `instr_f` in 32: instruction word read from IM at `pc_f`.
- `cmpout` in 1: branch-condition result for `instr_d`.
- `rs_data_d` in 32: forwarded GPR[rs] of `instr_d`, used by jr/jalr.
- `pc_f` out 32: current fetch address to IM.
- `instr_d` out 32: IF/ID instruction register.
- `pc_d` out 32: PC of `instr_d`.
- `pc8_d` out 32: `pc_d`+8, the link value for jal/jalr/bgezal.
- `redirect_d` out 1: combinational; 1 when `instr_d` transfers control this cycle.

## Operation
- Decode of `instr_d` (op = [31:26]):
  - Branch class: op 000100 beq, 000101 bne, 000110 blez, 000111 bgtz.
  - Branch class: op 000001 with rt [20:16] in {00000 bltz, 00001 bgez, 10001 bgezal}.
  - Jump class: op 000010 j, 000011 jal.
  - Register-jump class: op 000000 with funct [5:0] 001000 jr, 001001 jalr.
  - Everything else, including op 000000 funct 001010 movz, is not a transfer. `cmpout` is ignored for non-branch encodings even when 1.
- Next PC, priority order:
  - Register jump: `rs_data_d`.
  - Jump: {(`pc_d`+4)[31:28], `instr_d`[25:0], 2'b00}.
  - Branch with `cmpout`=1: `pc_d`+4+{{14{imm[15]}}, imm, 2'b00}, where imm = `instr_d`[15:0].
  - Otherwise: `pc_f`+4.
- `redirect_d` = register jump | jump | (branch & `cmpout`).
- All adds are 32-bit modulo 2^32; wrap-around is silent. Target alignment is not checked; a misaligned jr target is passed through unchanged.
- Delay slot: when `instr_d` redirects, `pc_f` already holds `pc_d`+4. That instruction enters IF/ID normally and the next `pc_f` is the target.

## Timing
- Reset (async, any cycle, including mid-stall or mid-redirect):
  - `pc_f`=`RESET_PC`.
  - `instr_d`=0 (a nop).
  - `pc_d`=`RESET_PC`.
  - `pc8_d`=`RESET_PC`+8.
  - `redirect_d`=0, since `instr_d`=0.
- First posedge after reset deasserts: `pc_f`←`RESET_PC`+4, IF/ID←{`instr_f`, `RESET_PC`}.
- Each posedge with `stall`=0: `pc_f`←next PC; `instr_d`←`instr_f`; `pc_d`←`pc_f`; `pc8_d`←`pc_f`+8.
- Each posedge with `stall`=1: all registers hold.
  - `redirect_d` and the next-PC mux still evaluate combinationally but do not commit.
  - The branch is re-evaluated on every cycle it sits in D.
  - The first unstalled edge commits using that cycle's `cmpout`/`rs_data_d`.
- Latency: a transfer in D takes effect on `pc_f` at the first unstalled posedge. Fetch-to-D latency is 1 cycle.

## Test plan
- Reset and sequential fetch:
  - Pulse `reset` between edges → `pc_f`=0x3000 and `instr_d`=0 immediately, without waiting for a clock edge.
  - Three clocks with nop fetches → `pc_f` 0x3004, 0x3008, 0x300C; `pc_d` trails by one cycle; `pc8_d`=`pc_d`+8.
- beq at `pc_d`=0x3004, imm=0x0003:
  - `cmpout`=1 → `redirect_d`=1; next `pc_f`=0x3014; delay-slot instruction at 0x3008 appears in `instr_d`.
  - `cmpout`=0 → next `pc_f`=0x300C.
- Backward branch: bgez at `pc_d`=0x3010, imm=0xFFFF, `cmpout`=1 → next `pc_f`=0x3010.
- Jumps:
  - jal, index 0x0000C10, at `pc_d`=0x3000 → next `pc_f`=0x3040; `pc8_d`=0x3008.
  - jr with `rs_data_d`=0x3100 → next `pc_f`=0x3100 regardless of `cmpout`.
- Stall during branch:
  - Taken bne in D, `stall`=1 for 2 cycles → `pc_f`, `instr_d`, `pc_d` unchanged.
  - `cmpout` toggles 0→1 during the stall and `stall` drops → redirect uses the final `cmpout`=1.
- movz and assertions:
  - movz in D with `cmpout`=1 → `redirect_d`=0; `pc_f` increments by 4.
  - Assert `reset` during a stalled redirect → all outputs return to reset values and no target is committed.
